// File: rtl/dmem.sv
// Byte-addressable data memory with a self-clearing start-up phase and a
// fixed-latency response pipeline (RD_LAT stages of valid/data/err).
module dmem #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          clr_we;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          oor;
  logic          err;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   rd_ext;

  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pe;
  logic [31:0]       pd [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    if (state == CLEAR) begin
      clr_we = 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) begin
        state_nxt   = RUN;
        clr_cnt_nxt = '0;
      end else begin
        clr_cnt_nxt = clr_cnt + 1'b1;
      end
    end
  end

  // Reset wins over a simultaneous request, so ready is masked by rst_n.
  assign req_ready = (state == RUN) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    idx  = req_addr[AW+1:2];
    lane = req_addr[1:0];
    oor  = (req_addr[31:2] >= 30'(DEPTH));
    err  = (req_size == 2'b11)
        || (req_size == 2'b01 && lane[0])
        || (req_size == 2'b10 && lane != 2'b00)
        || oor;

    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rd_word = mem[idx];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[8*lane +: 8];
    case (req_size)
      2'b00:   rd_ext = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
    if (req_we || err) rd_ext = '0;
  end

  // NOTE: the storage array has no reset branch; its contents are zeroed by
  // the CLEAR sweep instead, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_cnt] <= '0;
      end else if (accept && req_we && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance so later writes cannot alter it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && err;
      pd[0] <= accept ? rd_ext : 32'b0;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign rsp_valid = pv[RD_LAT-1];
  assign rsp_err   = pe[RD_LAT-1];
  assign rsp_rdata = pd[RD_LAT-1];

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: byte-array reference model plus a queue of
// expected responses keyed by the cycle in which each must appear.
module tb_dmem;

  localparam int DEPTH  = 64;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          edge_n = 0;
  logic [7:0]  mref [4*DEPTH];
  bit          m_run  = 1'b0;
  int          m_clr  = 0;
  rsp_t        exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int i;
    logic [15:0] h;
    i = int'(a);
    case (sz)
      2'd0:    return u ? 32'(mref[i]) : 32'(int'($signed(mref[i])));
      2'd1: begin
        h = {mref[i+1], mref[i]};
        return u ? 32'(h) : 32'(int'($signed(h)));
      end
      default: return {mref[i+3], mref[i+2], mref[i+1], mref[i]};
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) mref[int'(a) + k] = d[8*k +: 8];
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u,
                       input logic rst = 1'b1);
    rsp_t   r;
    logic   ev;
    logic [31:0] ed;
    logic   ee;
    rst_n = rst; req_valid = v; req_we = we; req_addr = a;
    req_wdata = d; req_size = sz; req_unsigned = u;
    @(posedge clk);
    edge_n++;
    if (!rst) begin
      m_run = 1'b0;
      m_clr = 0;
      exp_q.delete();
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_run = 1'b1;
        foreach (mref[i]) mref[i] = 8'h00;
      end
    end else if (v) begin
      r.due  = edge_n + RD_LAT - 1;
      r.err  = is_err(a, sz);
      r.data = (we || r.err) ? 32'h0 : model_load(a, sz, u);
      exp_q.push_back(r);
      if (we && !r.err) model_store(a, d, sz);
    end
    @(negedge clk);
    ev = 1'b0; ed = 32'h0; ee = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      r  = exp_q.pop_front();
      ev = 1'b1; ed = r.data; ee = r.err;
    end
    check("req_ready", 32'(req_ready), 32'(m_run && rst));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_rdata", rsp_rdata, ed);
    check("rsp_err",   32'(rsp_err), 32'(ee));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    cycle(1'b1, 1'b1, a, d, sz, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic u);
    cycle(1'b1, 1'b0, a, 32'h0, sz, u);
  endtask

  task automatic reset_and_clear(input string tag);
    int rise;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    rise = 0;
    for (int k = 1; k <= DEPTH + 3; k++) begin
      idle();
      if (req_ready === 1'b1 && rise == 0) rise = k;
    end
    check(tag, 32'(rise), 32'(DEPTH));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = 2'd0; req_unsigned = 1'b0;
    foreach (mref[i]) mref[i] = 8'hA5;

    reset_and_clear("ready_after_clear");
    rd(32'h0, 2'd2, 1'b0);
    rd(32'(4*DEPTH - 4), 2'd2, 1'b0);
    rd(32'h44, 2'd0, 1'b1);
    repeat (RD_LAT) idle();

    // Word write then signed/unsigned byte reads.
    wr(32'h10, 32'h80F0_7F01, 2'd2);
    for (int k = 0; k < 4; k++) rd(32'h10 + 32'(k), 2'd0, 1'b0);
    rd(32'h12, 2'd0, 1'b1);
    repeat (RD_LAT) idle();

    // Half write over an existing word.
    wr(32'h20, 32'h1122_3344, 2'd2);
    wr(32'h22, 32'h0000_BEEF, 2'd1);
    rd(32'h20, 2'd2, 1'b0);
    rd(32'h22, 2'd1, 1'b0);
    rd(32'h22, 2'd1, 1'b1);
    repeat (RD_LAT) idle();

    // Error accesses leave memory untouched.
    wr(32'h21, 32'hDEAD_BEEF, 2'd2);
    rd(32'h13, 2'd1, 1'b0);
    rd(32'h20, 2'd3, 1'b0);
    rd(32'(4*DEPTH), 2'd2, 1'b0);
    wr(32'h20, 32'hFFFF_FFFF, 2'd3);
    wr(32'(4*DEPTH + 2), 32'h1234, 2'd1);
    wr(32'hFFFF_FFF0, 32'h5555_5555, 2'd2);
    rd(32'h20, 2'd2, 1'b0);
    rd(32'h10, 2'd2, 1'b0);
    repeat (RD_LAT) idle();

    // Back-to-back reads through the pipeline.
    wr(32'h0, 32'hA000_0001, 2'd2);
    wr(32'h4, 32'hB000_0002, 2'd2);
    wr(32'h8, 32'hC000_0003, 2'd2);
    rd(32'h0, 2'd2, 1'b0);
    rd(32'h4, 2'd2, 1'b0);
    rd(32'h8, 2'd2, 1'b0);
    repeat (RD_LAT + 1) idle();

    // Read-after-write forwarding and in-flight read isolation.
    wr(32'h30, 32'h1357_9BDF, 2'd2);
    rd(32'h30, 2'd2, 1'b0);
    rd(32'h34, 2'd2, 1'b0);
    wr(32'h34, 32'h2468_ACE0, 2'd2);
    rd(32'h34, 2'd2, 1'b0);
    rd(32'h35, 2'd0, 1'b0);
    repeat (RD_LAT) idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 4*DEPTH + 8));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    repeat (RD_LAT) idle();

    // Reset with reads in flight: they must vanish and CLEAR must restart.
    wr(32'h40, 32'hCAFE_F00D, 2'd2);
    rd(32'h40, 2'd2, 1'b0);
    rd(32'h10, 2'd2, 1'b0);
    reset_and_clear("ready_after_reclear");
    rd(32'h40, 2'd2, 1'b0);
    rd(32'h10, 2'd2, 1'b0);
    rd(32'h22, 2'd1, 1'b0);
    repeat (RD_LAT + 1) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the memory size in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter RD_LAT, default 1, the request-to-response latency in cycles (legal 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, a request is present.
REQ-006 SHALL have port req_ready, output, 1, dmem can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, write (1) or read (0).
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_wdata, input, 32, the write data, LSB-aligned.
REQ-010 SHALL have port req_size, input, 2, the access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 SHALL have port req_unsigned, input, 1, zero-extend (1) or sign-extend (0) read data.
REQ-012 SHALL have port rsp_valid, output, 1, response pulse, one per accepted request.
REQ-013 SHALL have port rsp_rdata, output, 32, the extended read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1, the accepted request was misaligned, out of range or illegal-size.

Function
REQ-015 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; no queueing.
REQ-016 States SHALL be CLEAR and RUN; reset enters CLEAR with clear counter 0.
REQ-017 In CLEAR, one word per cycle SHALL be written to 0, indices 0..DEPTH-1, with req_ready=0; after index DEPTH-1 the FSM enters RUN.
REQ-018 In RUN, req_ready SHALL be 1 every cycle.
REQ-019 The word index SHALL be req_addr[31:2] and the byte lane req_addr[1:0].
REQ-020 The access SHALL be an error if req_size=11, or if half with addr[0]=1, or if word with addr[1:0]!=0, or if the word index is >= DEPTH.
REQ-021 An error access SHALL leave memory unchanged.
REQ-022 A legal write SHALL update only the addressed lanes: byte uses wdata[7:0] into lane addr[1:0]; half uses wdata[15:0] into lanes addr[1]*2..+1; word uses all 4 lanes.
REQ-023 A legal read SHALL extract the addressed byte or half, then sign- or zero-extend it per req_unsigned; a word read is returned unchanged.
REQ-024 The response for the request accepted at edge N SHALL appear with rsp_valid=1 for exactly the cycle following edge N+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
REQ-025 The response SHALL be pipelined through RD_LAT valid/data/err stages, sustaining one response per cycle with back-to-back requests.
REQ-026 Every response SHALL carry rsp_err, and rsp_rdata=0 whenever it is a write or an error.
REQ-027 A read accepted the cycle after a write to the same word SHALL return the post-write data.
REQ-028 Reads SHALL sample memory at acceptance; a later write SHALL not alter an in-flight read response.
REQ-029 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-030 With rst_n=0 at an edge, the block SHALL clear all response stages, drive rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0, and enter CLEAR.
REQ-031 A reset mid-operation SHALL drop in-flight responses and restart the clear from index 0; memory contents become 0 only once CLEAR completes.
REQ-032 Reset SHALL take priority over any simultaneous request.

Verification
REQ-033 Reset, then count cycles -> req_ready rises exactly DEPTH cycles after rst_n goes to 1; a word read of any address returns 0.
REQ-034 Word write 0x80F0_7F01 to 0x10, then byte reads of 0x10..0x13 signed -> 0x0000_0001, 0x0000_007F, 0xFFFF_FFF0, 0xFFFF_FF80; unsigned read of 0x12 -> 0x0000_00F0.
REQ-035 Half write 0xBEEF to 0x22 over word 0x1122_3344 at 0x20 -> word read returns 0xBEEF_3344; signed half read of 0x22 returns 0xFFFF_BEEF.
REQ-036 Word write to 0x21, half read of 0x13, size 11, and word read of 4*DEPTH -> each response has rsp_err=1 and rdata=0, and memory is unchanged.
REQ-037 With RD_LAT=3, back-to-back reads of 0x0, 0x4 and 0x8 -> three consecutive rsp_valid pulses starting 3 cycles after the first acceptance, data in order.
REQ-038 Assert rst_n=0 with 2 reads in flight -> no rsp_valid pulses afterward, and CLEAR restarts.
